// File: rtl/band_playback_scheduler.sv
// Shares one synchronous sample ROM among NUM_BANDS playback channels. Each 44 kHz
// frame it reads one sample per band, then publishes all band samples and their sum.
module band_playback_scheduler #(
    parameter int unsigned NUM_BANDS  = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DIV        = 100,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_BANDS*ADDR_WIDTH-1:0]    band_base_i,
    input  logic [NUM_BANDS*ADDR_WIDTH-1:0]    band_len_i,
    input  logic [NUM_BANDS-1:0]               start_i,
    input  logic [NUM_BANDS-1:0]               stop_i,
    input  logic [NUM_BANDS-1:0]               loop_i,
    output logic                               mem_en_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    input  logic [15:0]                        mem_dout_i,
    output logic [NUM_BANDS*16-1:0]            sample_out_o,
    output logic [16+$clog2(NUM_BANDS)-1:0]    mix_out_o,
    output logic                               frame_valid_o,
    output logic [NUM_BANDS-1:0]               active_o,
    output logic [NUM_BANDS-1:0]               done_o
);

    localparam int unsigned SW = 16;
    localparam int unsigned MW = SW + $clog2(NUM_BANDS);
    localparam int unsigned BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    // A frame must fit inside one divider period; the delay line supports 1 or 2.
    if (NUM_BANDS + RD_LAT + 2 > DIV) begin : g_bad_div
        $error("DIV too small for NUM_BANDS + RD_LAT + 2 cycles per frame");
    end
    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $error("RD_LAT must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_DRAIN   = 2'd2,
        S_PUBLISH = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [BW-1:0]          phase_q, phase_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   tick_c;

    logic [ADDR_WIDTH-1:0]  base_a [NUM_BANDS];
    logic [ADDR_WIDTH-1:0]  len_a  [NUM_BANDS];
    logic [ADDR_WIDTH-1:0]  ptr_q  [NUM_BANDS];
    logic [ADDR_WIDTH-1:0]  ptr_d  [NUM_BANDS];
    logic [SW-1:0]          shadow_q [NUM_BANDS];
    logic [SW-1:0]          shadow_d [NUM_BANDS];

    logic [NUM_BANDS-1:0]   active_q, active_d;
    logic [NUM_BANDS-1:0]   done_pend_q, done_pend_d;
    logic [NUM_BANDS-1:0]   start_pend_q, start_pend_d;
    logic [NUM_BANDS-1:0]   stop_pend_q, stop_pend_d;
    logic [NUM_BANDS-1:0]   done_q, done_d;

    logic [RD_LAT-1:0]      dl_vld_q, dl_act_q;
    logic [BW-1:0]          dl_idx_q [RD_LAT];

    logic [NUM_BANDS*SW-1:0] sample_q, sample_c;
    logic signed [MW-1:0]   mix_q, mix_c;
    logic                   frame_valid_q;

    logic                   issue_c, publish_c, slot_act_c;
    logic [BW-1:0]          slot_c;

    always_comb begin : unpack_cfg
        for (int b = 0; b < NUM_BANDS; b++) begin
            base_a[b] = band_base_i[b*ADDR_WIDTH +: ADDR_WIDTH];
            len_a[b]  = band_len_i[b*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Free-running frame divider.
    assign tick_c = (div_q == DW'(DIV - 1));
    assign div_d  = tick_c ? '0 : div_q + DW'(1);

    always_ff @(posedge clk or posedge rst) begin : div_reg
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // phase_q doubles as the ISSUE slot index and the DRAIN cycle count.
    always_comb begin : next_state
        state_d = state_q;
        phase_d = '0;
        case (state_q)
            S_IDLE: begin
                if (tick_c) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (phase_q == BW'(NUM_BANDS - 1)) state_d = S_DRAIN;
                else                               phase_d = phase_q + BW'(1);
            end
            S_DRAIN: begin
                if (phase_q == BW'(RD_LAT - 1)) state_d = S_PUBLISH;
                else                            phase_d = phase_q + BW'(1);
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        issue_c   = 1'b0;
        publish_c = 1'b0;
        case (state_q)
            S_ISSUE:   issue_c   = 1'b1;
            S_PUBLISH: publish_c = 1'b1;
            default: ;
        endcase
    end

    assign slot_c     = phase_q;
    assign slot_act_c = issue_c & active_q[slot_c];
    assign mem_en_o   = slot_act_c;
    assign mem_addr_o = base_a[slot_c] + ptr_q[slot_c];

    // Pointer advance during the slot, then control pulses applied at publish.
    always_comb begin : band_next
        ptr_d        = ptr_q;
        active_d     = active_q;
        done_pend_d  = done_pend_q;
        start_pend_d = start_pend_q | start_i;
        stop_pend_d  = stop_pend_q | stop_i;
        done_d       = '0;
        if (slot_act_c) begin
            if (ptr_q[slot_c] == len_a[slot_c] - ADDR_WIDTH'(1)) begin
                if (loop_i[slot_c]) begin
                    ptr_d[slot_c] = '0;
                end else begin
                    active_d[slot_c]    = 1'b0;
                    done_pend_d[slot_c] = 1'b1;
                end
            end else begin
                ptr_d[slot_c] = ptr_q[slot_c] + ADDR_WIDTH'(1);
            end
        end
        if (publish_c) begin
            done_d       = done_pend_q;
            done_pend_d  = '0;
            start_pend_d = start_i;
            stop_pend_d  = stop_i;
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (start_pend_q[b] && (len_a[b] != '0)) begin
                    ptr_d[b]    = '0;
                    active_d[b] = 1'b1;
                    done_d[b]   = 1'b0;
                end else if (stop_pend_q[b]) begin
                    active_d[b] = 1'b0;
                end
            end
        end
    end

    // Inactive slots still travel the delay line so their lane is zeroed.
    always_comb begin : capture
        shadow_d = shadow_q;
        if (dl_vld_q[RD_LAT-1]) begin
            shadow_d[dl_idx_q[RD_LAT-1]] = dl_act_q[RD_LAT-1] ? mem_dout_i : '0;
        end
    end

    always_comb begin : mix_sum
        mix_c    = '0;
        sample_c = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            mix_c = mix_c + MW'($signed(shadow_q[b]));
            sample_c[b*SW +: SW] = shadow_q[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin : data_reg
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                ptr_q[b]    <= '0;
                shadow_q[b] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) dl_idx_q[i] <= '0;
            dl_vld_q      <= '0;
            dl_act_q      <= '0;
            active_q      <= '0;
            done_pend_q   <= '0;
            start_pend_q  <= '0;
            stop_pend_q   <= '0;
            done_q        <= '0;
            sample_q      <= '0;
            mix_q         <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            shadow_q      <= shadow_d;
            dl_vld_q[0]   <= issue_c;
            dl_act_q[0]   <= slot_act_c;
            dl_idx_q[0]   <= slot_c;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_act_q[i] <= dl_act_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
            active_q      <= active_d;
            done_pend_q   <= done_pend_d;
            start_pend_q  <= start_pend_d;
            stop_pend_q   <= stop_pend_d;
            done_q        <= done_d;
            frame_valid_q <= publish_c;
            if (publish_c) begin
                sample_q <= sample_c;
                mix_q    <= mix_c;
            end
        end
    end

    assign sample_out_o  = sample_q;
    assign mix_out_o     = mix_q;
    assign frame_valid_o = frame_valid_q;
    assign active_o      = active_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_band_playback_scheduler.sv
// Directed bench for band_playback_scheduler: frame timing, looping/one-shot playback,
// mix arithmetic, control collisions and mid-frame reset, against a small ROM model.
module tb_band_playback_scheduler;

    localparam int unsigned NB = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned MW = 19;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB*AW-1:0]  band_base = '0;
    logic [NB*AW-1:0]  band_len  = '0;
    logic [NB-1:0]     start = '0;
    logic [NB-1:0]     stop  = '0;
    logic [NB-1:0]     loop_l = '0;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [15:0]       mem_dout = 16'hDEAD;
    logic [NB*16-1:0]  sample_out;
    logic [MW-1:0]     mix_out;
    logic              frame_valid;
    logic [NB-1:0]     active;
    logic [NB-1:0]     done;

    int                rom_mode = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                en_cnt   = 0;
    logic [15:0]       addr_log [$];

    band_playback_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .band_base_i   (band_base),
        .band_len_i    (band_len),
        .start_i       (start),
        .stop_i        (stop),
        .loop_i        (loop_l),
        .mem_en_o      (mem_en),
        .mem_addr_o    (mem_addr),
        .mem_dout_i    (mem_dout),
        .sample_out_o  (sample_out),
        .mix_out_o     (mix_out),
        .frame_valid_o (frame_valid),
        .active_o      (active),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // One-cycle ROM; garbage on the bus when not enabled.
    always @(posedge clk) begin
        if (mem_en) begin
            case (rom_mode)
                1:       mem_dout <= 16'h7FFF;
                2:       mem_dout <= 16'h8000;
                default: mem_dout <= mem_addr;
            endcase
        end else begin
            mem_dout <= 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt = en_cnt + 1;
            addr_log.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_fv(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_valid && n < 300);
        if (!frame_valid) check({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic pulse(input logic [NB-1:0] s, input logic [NB-1:0] p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = '0;
        stop  = '0;
    endtask

    function automatic logic [127:0] lane(input int b, input logic [15:0] v);
        logic [127:0] r;
        r = '0;
        r[b*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [15:0] log_head();
        return (addr_log.size() > 0) ? addr_log[0] : 16'hFFFF;
    endfunction

    initial begin
        int n;
        logic [15:0] exp_seq [4];
        exp_seq[0] = 16'h0100; exp_seq[1] = 16'h0101;
        exp_seq[2] = 16'h0102; exp_seq[3] = 16'h0100;

        // Reset state and idle frame timing
        @(posedge clk); #1;
        check("rst_sample", sample_out, '0);
        check("rst_mix", mix_out, '0);
        check("rst_fv", frame_valid, '0);
        check("rst_active", active, '0);
        check("rst_mem_en", mem_en, '0);
        @(posedge clk); #1 rst = 1'b0;
        wait_fv("idle1", n);
        check("idle_first_fv_cycle", n, 111);
        check("idle_sample", sample_out, '0);
        check("idle_mix", mix_out, '0);
        wait_fv("idle2", n);
        check("idle_period2", n, 100);
        wait_fv("idle3", n);
        check("idle_period3", n, 100);
        check("idle_mem_en_count", en_cnt, 0);

        // Single looping band 2
        band_base[2*AW +: AW] = 16'h0100;
        band_len[2*AW +: AW]  = 16'd3;
        loop_l[2] = 1'b1;
        pulse(8'h04, 8'h00);
        wait_fv("loop_a", n);
        check("loop_activate", active, 8'h04);
        check("loop_first_sample", sample_out, '0);
        addr_log.delete();
        for (int f = 0; f < 4; f++) begin
            wait_fv("loop_f", n);
            check($sformatf("loop_nreads_%0d", f), addr_log.size(), 1);
            check($sformatf("loop_addr_%0d", f), log_head(), exp_seq[f]);
            check($sformatf("loop_sample_%0d", f), sample_out, lane(2, exp_seq[f]));
            addr_log.delete();
        end
        pulse(8'h00, 8'h04);
        wait_fv("stop_f", n);
        check("stop_last_sample", sample_out, lane(2, 16'h0101));
        check("stop_active", active, 8'h00);
        addr_log.delete();
        wait_fv("stop_g", n);
        check("stop_silent", sample_out, '0);
        check("stop_no_reads", addr_log.size(), 0);

        // One-shot band 0
        band_base[0 +: AW] = 16'h0200;
        band_len[0 +: AW]  = 16'd2;
        loop_l[0] = 1'b0;
        pulse(8'h01, 8'h00);
        wait_fv("os_a", n);
        check("os_active_a", active, 8'h01);
        wait_fv("os_b", n);
        check("os_sample_b", sample_out, lane(0, 16'h0200));
        check("os_done_b", done, 8'h00);
        wait_fv("os_c", n);
        check("os_sample_c", sample_out, lane(0, 16'h0201));
        check("os_done_c", done, 8'h01);
        check("os_active_c", active, 8'h00);
        @(negedge clk);
        check("os_done_pulse_width", done, 8'h00);
        wait_fv("os_d", n);
        check("os_sample_d", sample_out, '0);
        check("os_done_d", done, 8'h00);

        // Mix arithmetic at both extremes
        for (int b = 0; b < NB; b++) begin
            band_base[b*AW +: AW] = 16'h0000;
            band_len[b*AW +: AW]  = 16'd4;
        end
        loop_l = 8'hFF;
        rom_mode = 1;
        pulse(8'hFF, 8'h00);
        wait_fv("mix_a", n);
        check("mix_active", active, 8'hFF);
        wait_fv("mix_b", n);
        check("mix_pos", mix_out, 19'h3FFF8);
        check("mix_pos_lanes", sample_out, {8{16'h7FFF}});
        rom_mode = 2;
        wait_fv("mix_c", n);
        check("mix_neg", mix_out, 19'h40000);
        check("mix_neg_lanes", sample_out, {8{16'h8000}});
        pulse(8'h00, 8'hFF);
        wait_fv("mix_d", n);
        check("mix_stop_all", active, 8'h00);

        // Control collisions
        rom_mode = 0;
        band_base[3*AW +: AW] = 16'h0300;
        band_len[3*AW +: AW]  = 16'd5;
        band_len[4*AW +: AW]  = 16'd0;
        band_base[5*AW +: AW] = 16'h0500;
        band_len[5*AW +: AW]  = 16'd4;
        pulse(8'h18, 8'h08);
        wait_fv("col_a", n);
        check("col_start_wins_len0_ignored", active, 8'h08);
        wait_fv("col_b", n);
        check("col_b_sample", sample_out, lane(3, 16'h0300));
        n = 0;
        while (!mem_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("col_issue_seen", mem_en, 1'b1);
        pulse(8'h20, 8'h00);
        wait_fv("col_c", n);
        check("col_c_sample", sample_out, lane(3, 16'h0301));
        check("col_c_active", active, 8'h28);
        wait_fv("col_d", n);
        check("col_d_sample", sample_out, lane(3, 16'h0302) | lane(5, 16'h0500));

        // Reset during DRAIN of the next frame
        repeat (98) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_sample", sample_out, '0);
        check("mrst_mix", mix_out, '0);
        check("mrst_active", active, '0);
        check("mrst_fv", frame_valid, '0);
        check("mrst_mem_en", mem_en, '0);
        @(posedge clk); #1 rst = 1'b0;
        wait_fv("mrst_next", n);
        check("mrst_first_fv_cycle", n, 111);
        check("mrst_active_after", active, '0);
        check("mrst_sample_after", sample_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
